// File: rtl/depacketizer_4_serial_pkg.sv
// Shared definitions for the 4-flit packetizer/depacketizer pair: flit header
// bit positions, payload-width helpers and the depacketizer state encoding.
package depacketizer_4_serial_pkg;

  localparam int MAX_FLITS = 4;

  // Header bit offsets counted down from the flit MSB.
  localparam int FLIT_VALID_OFS = 0;
  localparam int FLIT_HEAD_OFS  = 1;
  localparam int FLIT_TAIL_OFS  = 2;
  localparam int FLIT_HDR_BITS  = 3;

  typedef enum logic {IDLE, BODY} state_t;

  // Actual payload bits carried by flit idx: min(ideal, bits still to send).
  function automatic int flit_payload_width(input int idx, input int fw, input int aw,
                                            input int vw, input int wo);
    int rem, ideal, w, res;
    rem = wo;
    res = 0;
    for (int i = 0; i < MAX_FLITS; i++) begin
      ideal = (i == 0) ? fw - FLIT_HDR_BITS - aw - vw : fw - FLIT_HDR_BITS - vw;
      if (ideal < 0) ideal = 0;
      w = (ideal < rem) ? ideal : rem;
      if (i == idx) res = w;
      rem = rem - w;
    end
    return res;
  endfunction

  // Payload bits already carried by the flits before idx (MSB-first order).
  function automatic int flit_payload_base(input int idx, input int fw, input int aw,
                                           input int vw, input int wo);
    int sum;
    sum = 0;
    for (int i = 0; i < MAX_FLITS; i++)
      if (i < idx) sum = sum + flit_payload_width(i, fw, aw, vw, wo);
    return sum;
  endfunction

  // Number of flits that carry at least one payload bit.
  function automatic int num_flits(input int fw, input int aw, input int vw, input int wo);
    int n;
    n = 0;
    for (int i = 0; i < MAX_FLITS; i++)
      if (flit_payload_width(i, fw, aw, vw, wo) > 0) n = n + 1;
    return n;
  endfunction

endpackage

// File: rtl/depacketizer_4_serial_out.sv
// One-entry valid/ready output register holding the reassembled word.
module depkt_out_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  // Can take a new word when empty or when the held word leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  // Load on a new word; otherwise drop valid once the consumer has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/depacketizer_4_serial.sv
// Serial 4-flit depacketizer: strips flit headers, reassembles the payload
// MSB-first into one word, and flags framing errors with a saturating count.
module depacketizer_4_serial
  import depacketizer_4_serial_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int FLIT_WIDTH       = 9,
  parameter int WIDTH_OUT        = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_WIDTH-1:0]    flit_in,
  input  logic                     flit_valid_in,
  output logic                     flit_ready_out,
  output logic [WIDTH_OUT-1:0]     data_out,
  output logic [ADDRESS_WIDTH-1:0] dst_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     err_out,
  output logic [7:0]               err_count
);

  localparam int NUM_FLITS = num_flits(FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH, WIDTH_OUT);
  localparam int CW        = $clog2(MAX_FLITS + 1);
  localparam int IW        = $clog2(MAX_FLITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_FLITS);

  localparam int VLD_BIT   = FLIT_WIDTH - 1 - FLIT_VALID_OFS;
  localparam int HEAD_BIT  = FLIT_WIDTH - 1 - FLIT_HEAD_OFS;
  localparam int TAIL_BIT  = FLIT_WIDTH - 1 - FLIT_TAIL_OFS;
  localparam int DST_MSB   = FLIT_WIDTH - 1 - FLIT_HDR_BITS - VC_ADDRESS_WIDTH;
  localparam int HEAD_PMSB = DST_MSB - ADDRESS_WIDTH;
  localparam int BODY_PMSB = DST_MSB;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n, cnt_inc;
  logic [WIDTH_OUT-1:0]    asm_q, asm_n;
  logic [ADDRESS_WIDTH-1:0] dst_q, dst_n;
  logic                    take, is_head, is_tail, done, err;
  logic                    unused_flit;

  // Flit k's payload already shifted into its place in the word, zeros elsewhere.
  logic [MAX_FLITS-1:0][WIDTH_OUT-1:0] slice;

  for (genvar k = 0; k < MAX_FLITS; k++) begin : g_slice
    localparam int W    = flit_payload_width(k, FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH, WIDTH_OUT);
    localparam int BASE = flit_payload_base(k, FLIT_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH, WIDTH_OUT);
    localparam int PMSB = (k == 0) ? HEAD_PMSB : BODY_PMSB;
    if (W > 0) begin : g_on
      assign slice[k] = WIDTH_OUT'(flit_in[PMSB -: W]) << (WIDTH_OUT - BASE - W);
    end else begin : g_off
      assign slice[k] = '0;
    end
  end

  // VC and padding bits carry nothing this block needs.
  assign unused_flit = ^flit_in;

  assign take    = flit_valid_in && flit_ready_out && flit_in[VLD_BIT];
  assign is_head = flit_in[HEAD_BIT];
  assign is_tail = flit_in[TAIL_BIT];
  assign cnt_inc = cnt + CW'(1);

  // Framing FSM: decide where each accepted flit goes and whether it completes or breaks a packet.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    asm_n   = asm_q;
    dst_n   = dst_q;
    done    = 1'b0;
    err     = 1'b0;
    if (take) begin
      if (is_head) begin
        // A head always starts a fresh packet; mid-packet it also aborts the old one.
        err   = (state == BODY);
        asm_n = slice[0];
        dst_n = flit_in[DST_MSB -: ADDRESS_WIDTH];
        cnt_n = CW'(1);
        if (NUM_FLITS == 1 && is_tail) begin
          done    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          state_n = BODY;
        end
      end else if (state == IDLE) begin
        err = 1'b1;
      end else begin
        asm_n = asm_q | slice[cnt[IW-1:0]];
        cnt_n = cnt_inc;
        if (is_tail) begin
          done    = (cnt_inc == LAST_CNT);
          err     = (cnt_inc != LAST_CNT);
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_inc == LAST_CNT) begin
          err     = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
    end
  end

  // Assembly state: FSM state, flit count, partial word and captured destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      asm_q <= '0;
      dst_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      asm_q <= asm_n;
      dst_q <= dst_n;
    end
  end

  // Error pulse and saturating error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_out   <= 1'b0;
      err_count <= '0;
    end else begin
      err_out <= err;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  depkt_out_reg #(.DW(ADDRESS_WIDTH + WIDTH_OUT)) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (done),
    .in_data   ({dst_n, asm_n}),
    .in_ready  (flit_ready_out),
    .out_valid (valid_out),
    .out_data  ({dst_out, data_out}),
    .out_ready (ready_in)
  );

endmodule

// File: tb/tb_depacketizer_4_serial.sv
// Directed bench for depacketizer_4_serial with a packet-level reference model.
module tb_depacketizer_4_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  flit_in;
  logic        flit_valid_in;
  logic        flit_ready_out;
  logic [11:0] data_out;
  logic [3:0]  dst_out;
  logic        valid_out;
  logic        ready_in;
  logic        err_out;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  depacketizer_4_serial dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_valid_in  (flit_valid_in),
    .flit_ready_out (flit_ready_out),
    .data_out       (data_out),
    .dst_out        (dst_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .err_out        (err_out),
    .err_count      (err_count)
  );

  typedef struct packed { logic [3:0] dst; logic [11:0] data; } word_t;

  // Reference model: a packet is a head plus exactly three more flits; payload
  // bits per flit are 1,5,5,1, concatenated first-to-last.
  word_t       exp_q[$];
  int          pw[4] = '{1, 5, 5, 1};
  bit          in_pkt;
  int          nfl;
  logic [11:0] acc;
  logic [3:0]  mdst;
  int          model_err;
  int          seen_err;
  int          hs_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_flit(input logic [8:0] f);
    if (!f[8]) return;
    if (f[7]) begin
      if (in_pkt) model_err++;
      in_pkt = 1'b1;
      nfl    = 1;
      mdst   = f[4:1];
      acc    = 12'(f[0]);
    end else if (!in_pkt) begin
      model_err++;
    end else begin
      nfl++;
      acc = (acc << pw[nfl-1]) | 12'(f[4:0] >> (5 - pw[nfl-1]));
      if (f[6]) begin
        in_pkt = 1'b0;
        if (nfl == 4) exp_q.push_back({mdst, acc});
        else model_err++;
      end else if (nfl == 4) begin
        in_pkt = 1'b0;
        model_err++;
      end
    end
  endtask

  // Offer one flit (called at a falling edge); returns at the falling edge after acceptance.
  task automatic send(input logic [8:0] f);
    int t = 0;
    flit_in       = f;
    flit_valid_in = 1'b1;
    #1;
    while (!flit_ready_out && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!flit_ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: flit %h never accepted", f);
    end else begin
      @(posedge clk);
      model_flit(f);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    flit_valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err_pulses"}, seen_err, model_err);
    check({tag, "_err_count"}, err_count, (model_err > 255) ? 255 : model_err);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // Per-cycle compare against the model and the handshake rules.
  logic        pv, pr;
  logic [11:0] pd;
  logic [3:0]  pdst;
  always @(negedge clk) begin
    word_t w;
    #2;
    if (rst) begin
      seen_err = 0;
      pv       = 1'b0;
    end else begin
      check("flit_ready", flit_ready_out, !valid_out || ready_in);
      if (pv && !pr) begin
        check("hold_valid", valid_out, 1);
        check("hold_data", data_out, pd);
        check("hold_dst", dst_out, pdst);
      end
      if (err_out) seen_err++;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h/%h expected none", dst_out, data_out);
        end else begin
          w = exp_q.pop_front();
          check("word_data", data_out, w.data);
          check("word_dst", dst_out, w.dst);
          hs_cyc.push_back(cyc);
        end
      end
      pv   = valid_out;
      pr   = ready_in;
      pd   = data_out;
      pdst = dst_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flit_in = '0; flit_valid_in = 1'b0; ready_in = 1'b1;
    in_pkt = 1'b0; nfl = 0; acc = '0; mdst = '0; model_err = 0; seen_err = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pdst = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_dst", dst_out, 0);
    check("rst_err", err_out, 0);
    check("rst_errcnt", err_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single packet 12'hABC to dst 5.
    send(9'h18B); send(9'h10A); send(9'h11E); send(9'h140);
    flit_valid_in = 1'b0;
    #1;
    check("t1_valid", valid_out, 1);
    check("t1_data", data_out, 12'hABC);
    check("t1_dst", dst_out, 4'h5);
    check("t1_model_n", exp_q.size(), 1);
    if (exp_q.size() == 1) check("t1_model_word", exp_q[0], {4'h5, 12'hABC});
    idle(3);
    check_err("t1");

    // Back-to-back packets, no idle cycles.
    hs_cyc.delete();
    send(9'h18B); send(9'h10A); send(9'h11E); send(9'h140);
    send(9'h18A); send(9'h104); send(9'h111); send(9'h150);
    idle(3);
    check("t2_words", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check("t2_gap", hs_cyc[1] - hs_cyc[0], 4);
    check("t2_last_data", data_out, 12'h123);
    check_err("t2");

    // Backpressure: first word held, second packet stalls until ready.
    ready_in = 1'b0;
    send(9'h18B); send(9'h10A); send(9'h11E); send(9'h140);
    flit_valid_in = 1'b0;
    #1;
    check("t3_valid", valid_out, 1);
    check("t3_data", data_out, 12'hABC);
    check("t3_fready", flit_ready_out, 0);
    fork
      begin
        repeat (6) @(negedge clk);
        ready_in = 1'b1;
      end
      begin
        send(9'h18A); send(9'h104); send(9'h111); send(9'h150);
      end
    join
    idle(3);
    check_err("t3");

    // Orphan body flit in IDLE, then a good packet.
    send(9'h10A);
    idle(3);
    check("t4_errcnt", err_count, 1);
    check("t4_valid", valid_out, 0);
    send(9'h18A); send(9'h104); send(9'h111); send(9'h150);
    idle(3);
    check_err("t4");

    // Head flit mid-packet restarts assembly.
    send(9'h18B); send(9'h10A); send(9'h18B); send(9'h10A); send(9'h11E); send(9'h140);
    idle(3);
    check("t5_errcnt", err_count, 2);
    check("t5_data", data_out, 12'hABC);
    check_err("t5");

    // Flit with its valid bit clear is ignored mid-packet.
    send(9'h18A); send(9'h0AB); send(9'h104); send(9'h111); send(9'h150);
    idle(3);
    check("t6_errcnt", err_count, 2);
    check("t6_data", data_out, 12'h123);
    check_err("t6");

    // Early tail.
    send(9'h18B); send(9'h140);
    idle(3);
    check("t7_errcnt", err_count, 3);
    check("t7_valid", valid_out, 0);
    check_err("t7");

    // Asynchronous reset mid-packet.
    send(9'h18B); send(9'h10A);
    flit_valid_in = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("t8_valid", valid_out, 0);
    check("t8_data", data_out, 0);
    check("t8_dst", dst_out, 0);
    check("t8_errcnt", err_count, 0);
    in_pkt = 1'b0;
    model_err = 0;
    exp_q.delete();
    @(negedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    send(9'h18B); send(9'h10A); send(9'h11E); send(9'h140);
    idle(3);
    check("t8_after_data", data_out, 12'hABC);
    check_err("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
